fetch_queue: RTL

- Instruction-fetch front end that supplies the 16-bit pipelined datapath's decode stage. It is the producer side of the instruction stream that the pipeline consumes.
- Issues word fetches to a fixed-latency instruction memory and buffers returned instructions with their PC in a small FIFO.
- Presents instructions to decode under a stall handshake.
- Flushes and redirects on a taken branch.

---
 rtl/fetch_queue.sv | 111 +++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues fixed-latency word fetches and
// buffers returned instructions with their PC for the decode stage.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [15:0]              imem_addr,
    input  logic [15:0]              imem_rdata,
    output logic                     instr_valid,
    output logic [15:0]              instr,
    output logic [15:0]              instr_pc,
    output logic [15:0]              instr_plus2,
    input  logic                     stall,
    input  logic                     branch_taken,
    input  logic [15:0]              branch_addr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int          PW  = $clog2(DEPTH);
    localparam int          CW  = PW + 1;
    localparam logic [15:0] RPC = {RESET_PC[15:1], 1'b0};

    logic [15:0]   mem_instr [DEPTH];
    logic [15:0]   mem_pc    [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_nx;
    logic [15:0]   fetch_pc;
    logic [15:0]   inflight_pc;
    logic [15:0]   target;
    logic          inflight;
    logic          push;
    logic          pop;
    logic          issue;
    logic          bypass;
    logic [CW-1:0] count_nx;
    logic [CW:0]   need;

    assign instr_valid = (count != '0);
    assign target      = {branch_addr[15:1], 1'b0};

    always_comb begin
        pop      = instr_valid & ~stall & ~branch_taken;
        push     = inflight & ~branch_taken;
        count_nx = count + CW'(push) - CW'(pop);
        // Reserve a slot for the request already on the bus as well as
        // the one about to be issued, so no response is ever dropped.
        need     = {1'b0, count_nx} + (CW+1)'(imem_req) + (CW+1)'(1);
        issue    = (need <= (CW+1)'(DEPTH));
        rd_nx    = rd_ptr + PW'(pop);
        bypass   = (count == CW'(pop));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= imem_rdata;
            mem_pc[wr_ptr]    <= inflight_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_req    <= 1'b0;
            imem_addr   <= RPC;
            fetch_pc    <= RPC;
            inflight    <= 1'b0;
            inflight_pc <= RPC;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_plus2 <= '0;
        end else if (branch_taken) begin
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            inflight    <= 1'b0;
            imem_req    <= 1'b1;
            imem_addr   <= target;
            fetch_pc    <= target + 16'd2;
        end else begin
            count       <= count_nx;
            rd_ptr      <= rd_nx;
            wr_ptr      <= wr_ptr + PW'(push);
            inflight    <= imem_req;
            inflight_pc <= imem_addr;
            imem_req    <= issue;
            if (issue) begin
                imem_addr <= fetch_pc;
                fetch_pc  <= fetch_pc + 16'd2;
            end
            // Head registers hold their last value while the queue is empty.
            if (count_nx != '0) begin
                if (bypass) begin
                    instr       <= imem_rdata;
                    instr_pc    <= inflight_pc;
                    instr_plus2 <= inflight_pc + 16'd2;
                end else begin
                    instr       <= mem_instr[rd_nx];
                    instr_pc    <= mem_pc[rd_nx];
                    instr_plus2 <= mem_pc[rd_nx] + 16'd2;
                end
            end
        end
    end

endmodule
